// File: rtl/bayer_pkg.sv
// Shared types and constants for the Bayer-to-greyscale binning block:
// mosaic patterns, output modes, luma weights and the quad-to-colour mapping.
package bayer_pkg;

    typedef enum logic [1:0] {
        RGGB,
        BGGR,
        GRBG,
        GBRG
    } pattern_e;

    typedef enum logic {
        MODE_AVG,
        MODE_LUMA
    } mode_e;

    // Weights sum to 256 so a flat field passes through the >>8 unchanged.
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 75;
    localparam int LUMA_B = 29;

    // Widest raw pixel the shared colour mapping can carry.
    localparam int PIX_MAX_W = 16;

    typedef logic [PIX_MAX_W-1:0] pix_t;

    typedef struct packed {
        pix_t p00;
        pix_t p01;
        pix_t p10;
        pix_t p11;
    } quad_t;

    typedef struct packed {
        pix_t r;
        pix_t g1;
        pix_t g2;
        pix_t b;
    } rgb_t;

    function automatic rgb_t quad_to_rgb(pattern_e pattern, quad_t quad);
        rgb_t rgb;
        rgb = '{r: quad.p00, g1: quad.p01, g2: quad.p10, b: quad.p11};
        case (pattern)
            RGGB: rgb = '{r: quad.p00, g1: quad.p01, g2: quad.p10, b: quad.p11};
            BGGR: rgb = '{r: quad.p11, g1: quad.p01, g2: quad.p10, b: quad.p00};
            GRBG: rgb = '{r: quad.p01, g1: quad.p00, g2: quad.p11, b: quad.p10};
            GBRG: rgb = '{r: quad.p10, g1: quad.p00, g2: quad.p11, b: quad.p01};
            default: rgb = '{r: quad.p00, g1: quad.p01, g2: quad.p10, b: quad.p11};
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/bayer_line_buf.sv
// One-line pixel store with a registered read port. Read and write share the
// enable; on a shared address the read returns the value from before the write.
module bayer_line_buf #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data_q        <= mem_q[rd_addr];
            mem_q[wr_addr]   <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bayer_grey_bin.sv
// Streaming Bayer mosaic to greyscale with 2x2 binning: one grey sample per
// Bayer quad, either a plain average or a luma-weighted sum.
module bayer_grey_bin
    import bayer_pkg::*;
#(
    parameter int       PIX_W   = 12,
    parameter int       LINE_W  = 640,
    parameter int       FRAME_H = 480,
    parameter pattern_e PATTERN = RGGB,
    localparam int      X_W     = (LINE_W / 2 > 1) ? $clog2(LINE_W / 2) : 1,
    localparam int      Y_W     = (FRAME_H / 2 > 1) ? $clog2(FRAME_H / 2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
    input  mode_e            mode,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic             frame_done
);

    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = $clog2(FRAME_H);
    localparam int SUM_W  = PIX_W + 2;
    localparam int LUMA_W = PIX_MAX_W + 8;

    logic [COL_W-1:0] col_q, col_d, cur_col, nxt_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic [PIX_W-1:0] tl_q, tl_d, bl_q, bl_d;
    logic [PIX_W-1:0] top_pix;
    logic             last_col, last_row, quad_done;

    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic [X_W-1:0]   out_x_q, out_x_d;
    logic [Y_W-1:0]   out_y_q, out_y_d;
    logic             frame_done_q, frame_done_d;

    rgb_t             rgb;
    logic [SUM_W-1:0] avg_sum;
    logic [LUMA_W-1:0] luma_sum;
    logic [PIX_W-1:0] grey;

    // The read address runs one pixel ahead of the write address so the
    // previous-row pixel is already registered when its partner arrives.
    bayer_line_buf #(
        .DATA_W (PIX_W),
        .DEPTH  (LINE_W),
        .ADDR_W (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .en      (in_valid),
        .wr_addr (cur_col),
        .wr_data (in_pix),
        .rd_addr (nxt_col),
        .rd_data (top_pix)
    );

    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_col = (cur_col == COL_W'(LINE_W - 1));
        last_row = (cur_row == ROW_W'(FRAME_H - 1));
        nxt_col  = last_col ? '0 : cur_col + COL_W'(1);

        col_d = col_q;
        row_d = row_q;
        tl_d  = tl_q;
        bl_d  = bl_q;
        if (in_valid) begin
            col_d = nxt_col;
            if (last_col) begin
                row_d = last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                row_d = cur_row;
            end
            if (!cur_col[0]) begin
                tl_d = top_pix;
                bl_d = in_pix;
            end
        end
        quad_done = in_valid && cur_col[0] && cur_row[0];
    end

    always_comb begin
        rgb = quad_to_rgb(PATTERN, '{p00: pix_t'(tl_q), p01: pix_t'(top_pix),
                                     p10: pix_t'(bl_q), p11: pix_t'(in_pix)});
        avg_sum = SUM_W'(tl_q) + SUM_W'(top_pix) + SUM_W'(bl_q) + SUM_W'(in_pix);
        luma_sum = LUMA_W'(LUMA_R) * LUMA_W'(rgb.r)
                 + LUMA_W'(LUMA_G) * (LUMA_W'(rgb.g1) + LUMA_W'(rgb.g2))
                 + LUMA_W'(LUMA_B) * LUMA_W'(rgb.b);
        grey = (mode == MODE_LUMA) ? PIX_W'(luma_sum >> 8) : PIX_W'(avg_sum >> 2);

        out_valid_d  = quad_done;
        frame_done_d = quad_done && last_col && last_row;
        out_pix_d    = quad_done ? grey : out_pix_q;
        out_x_d      = quad_done ? X_W'(cur_col >> 1) : out_x_q;
        out_y_d      = quad_done ? Y_W'(cur_row >> 1) : out_y_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            tl_q         <= '0;
            bl_q         <= '0;
            out_valid_q  <= 1'b0;
            out_pix_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            tl_q         <= tl_d;
            bl_q         <= bl_d;
            out_valid_q  <= out_valid_d;
            out_pix_q    <= out_pix_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pix    = out_pix_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign frame_done = frame_done_q;

endmodule
